pipe_stage_reg: RTL and testbench

PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

---
 rtl/pipe_pkg.sv | 13 +
 rtl/pipe_slice.sv | 103 ++++++++++
 rtl/pipe_stage_reg.sv | 86 ++++++++
 tb/tb_pipe_stage_reg.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline stage register: the NOP payload and
// the helper that sizes the occupancy counter.
package pipe_pkg;

  // RISC-V "addi x0, x0, 0": the payload an empty slice presents.
  localparam logic [31:0] NOP_DATA = 32'h0000_0013;

  // Occupancy must be able to count up to 2*DEPTH when skid buffers exist.
  function automatic int occ_w(input int depth);
    return $clog2(2 * depth + 1);
  endfunction

endpackage

// File: rtl/pipe_slice.sv
// One register slice of the pipeline stage: a valid bit plus payload.
// Build option: define PIPE_SKID_EN to add a one-entry skid buffer and make
// in_ready a registered output; otherwise in_ready = out_ready || !valid.
module pipe_slice
  import pipe_pkg::*;
#(
  parameter int                DATA_W     = 32,
  parameter logic [DATA_W-1:0] FLUSH_DATA = DATA_W'(NOP_DATA)
) (
  input  logic              clk,
  input  logic              reset_i,
  input  logic              flush_i,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data
);

  logic clear;
  assign clear = reset_i || flush_i;

`ifdef PIPE_SKID_EN
  logic              main_valid, skid_valid, ready_q;
  logic [DATA_W-1:0] main_data, skid_data;
  logic              main_valid_d, skid_valid_d;
  logic [DATA_W-1:0] main_data_d, skid_data_d;
  logic              in_fire, main_free;

  assign in_fire   = in_valid && ready_q;
  assign main_free = !main_valid || out_ready;

  // Next-state: refill main from skid first, else from input; park input in
  // skid when main is stalled.
  always_comb begin
    // NOTE: every output gets a default first, so no path can infer a latch.
    main_valid_d = main_valid;
    main_data_d  = main_data;
    skid_valid_d = skid_valid;
    skid_data_d  = skid_data;
    if (main_free) begin
      if (skid_valid) begin
        main_valid_d = 1'b1;
        main_data_d  = skid_data;
        skid_valid_d = 1'b0;
        skid_data_d  = FLUSH_DATA;
      end else begin
        main_valid_d = in_fire;
        main_data_d  = in_fire ? in_data : FLUSH_DATA;
      end
    end else if (in_fire) begin
      skid_valid_d = 1'b1;
      skid_data_d  = in_data;
    end
  end

  // State update; ready is registered from the next skid state.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so each slice samples its neighbour's
    // pre-edge value.
    if (clear) begin
      // NOTE: payloads are reset too, because an idle slice must present
      // FLUSH_DATA rather than stale data.
      main_valid <= 1'b0;
      main_data  <= FLUSH_DATA;
      skid_valid <= 1'b0;
      skid_data  <= FLUSH_DATA;
      ready_q    <= 1'b1;
    end else begin
      main_valid <= main_valid_d;
      main_data  <= main_data_d;
      skid_valid <= skid_valid_d;
      skid_data  <= skid_data_d;
      ready_q    <= !skid_valid_d;
    end
  end

  assign in_ready  = ready_q;
  assign out_valid = main_valid;
  assign out_data  = main_data;
`else
  logic              valid_q;
  logic [DATA_W-1:0] data_q;

  assign in_ready = out_ready || !valid_q;

  // Load whenever the slice is empty or downstream takes the current entry.
  always_ff @(posedge clk) begin
    if (clear) begin
      valid_q <= 1'b0;
      data_q  <= FLUSH_DATA;
    end else if (in_ready) begin
      valid_q <= in_valid;
      data_q  <= in_valid ? in_data : FLUSH_DATA;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;
`endif

endmodule

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register: DEPTH chained valid/ready slices with flush and an
// occupancy counter. Build option: define PIPE_SKID_EN for skid buffering
// and registered in_ready (capacity 2*DEPTH instead of DEPTH).
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int                DATA_W     = 32,
  parameter int                DEPTH      = 1,
  parameter logic [DATA_W-1:0] FLUSH_DATA = DATA_W'(NOP_DATA)
) (
  input  logic                      clk,
  input  logic                      reset_i,
  input  logic                      flush_i,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [DATA_W-1:0]         in_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DATA_W-1:0]         out_data,
  output logic [occ_w(DEPTH)-1:0]   occupancy
);

  localparam int               OCC_W   = occ_w(DEPTH);
  localparam logic [OCC_W-1:0] OCC_ONE = OCC_W'(1);

  for (genvar i = 0; i < DEPTH; i++) begin : g_slice
    logic              up_valid, down_ready, rdy, vld;
    logic [DATA_W-1:0] up_data, dat;

    if (i == 0) begin : g_head
      assign up_valid = in_valid;
      assign up_data  = in_data;
    end else begin : g_link
      assign up_valid = g_slice[i-1].vld;
      assign up_data  = g_slice[i-1].dat;
    end

    if (i == DEPTH - 1) begin : g_tail
      assign down_ready = out_ready;
    end else begin : g_fwd
      assign down_ready = g_slice[i+1].rdy;
    end

    pipe_slice #(
      .DATA_W     (DATA_W),
      .FLUSH_DATA (FLUSH_DATA)
    ) u_slice (
      .clk       (clk),
      .reset_i   (reset_i),
      .flush_i   (flush_i),
      .in_valid  (up_valid),
      .in_ready  (rdy),
      .in_data   (up_data),
      .out_valid (vld),
      .out_ready (down_ready),
      .out_data  (dat)
    );
  end

  // Flush and reset both refuse the input so a dropped word never handshakes.
  assign in_ready  = g_slice[0].rdy && !flush_i && !reset_i;
  assign out_valid = g_slice[DEPTH-1].vld;
  assign out_data  = g_slice[DEPTH-1].dat;

  logic             in_fire, out_fire;
  logic [OCC_W-1:0] occ_q;

  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;

  // Track entries held: +1 per input transfer, -1 per output transfer.
  always_ff @(posedge clk) begin
    if (reset_i || flush_i) begin
      occ_q <= '0;
    end else begin
      case ({in_fire, out_fire})
        2'b10:   occ_q <= occ_q + OCC_ONE;
        2'b01:   occ_q <= occ_q - OCC_ONE;
        default: occ_q <= occ_q;
      endcase
    end
  end

  assign occupancy = occ_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg: directed scenarios plus a random
// valid/ready run, compared every cycle against a queue-based model.
module tb_pipe_stage_reg;
  import pipe_pkg::*;

  localparam int          DATA_W = 32;
  localparam int          DEPTH  = 3;
  localparam int          OCC_W  = occ_w(DEPTH);
  localparam logic [31:0] NOP    = 32'h0000_0013;
`ifdef PIPE_SKID_EN
  localparam int CAP = 2 * DEPTH;
`else
  localparam int CAP = DEPTH;
`endif

  logic              clk = 1'b0;
  logic              reset_i, flush_i, in_valid, in_ready, out_valid, out_ready;
  logic [DATA_W-1:0] in_data, out_data;
  logic [OCC_W-1:0]  occupancy;

  always #5 clk = ~clk;

  pipe_stage_reg #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) dut (
    .clk       (clk),
    .reset_i   (reset_i),
    .flush_i   (flush_i),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .occupancy (occupancy)
  );

  // Model: entries in acceptance order with cycles elapsed since acceptance.
  typedef struct {
    logic [31:0] data;
    int          age;
  } entry_t;

  entry_t      model_q[$];
  logic [31:0] out_log[$];
  int          out_cyc[$];
  int          checks = 0, failures = 0, cyc = 0, max_occ = 0;
  logic        prev_hold = 1'b0;
  logic [31:0] prev_data = NOP;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // One clock cycle: drive at negedge, check against the model, update at posedge.
  task automatic step(input logic r, input logic f, input logic iv,
                      input logic [31:0] id, input logic ordy, output logic took);
    logic        exp_ov, exp_rdy, in_fire, out_fire;
    logic [31:0] exp_od;
    @(negedge clk);
    reset_i = r; flush_i = f; in_valid = iv; in_data = id; out_ready = ordy;
    #1;
    if (prev_hold) check("stall_stable", out_data, prev_data);
`ifdef PIPE_SKID_EN
    exp_ov  = out_valid;
    exp_rdy = in_ready;
    if (out_valid)
      check("skid_latency", 32'(model_q.size() > 0 && model_q[0].age >= DEPTH - 1), 32'd1);
    if (r || f || model_q.size() >= CAP) check("skid_ready_cap", 32'(in_ready), 32'd0);
`else
    exp_ov  = (model_q.size() > 0) && (model_q[0].age >= DEPTH - 1);
    exp_rdy = !r && !f && (ordy || model_q.size() < DEPTH);
    check("out_valid", 32'(out_valid), 32'(exp_ov));
    check("in_ready", 32'(in_ready), 32'(exp_rdy));
`endif
    exp_od = (exp_ov && model_q.size() > 0) ? model_q[0].data : NOP;
    check("out_data", out_data, exp_od);
    check("occupancy", 32'(occupancy), 32'(model_q.size()));
    if (int'(occupancy) > max_occ) max_occ = int'(occupancy);
    in_fire  = iv && exp_rdy;
    out_fire = exp_ov && ordy && !r;
    if (out_fire) begin
      out_log.push_back(out_data);
      out_cyc.push_back(cyc);
    end
    prev_hold = exp_ov && !ordy && !r && !f;
    prev_data = exp_od;
    took      = in_fire;
    @(posedge clk);
    if (r || f) begin
      model_q.delete();
    end else begin
      if (out_fire) void'(model_q.pop_front());
      foreach (model_q[i]) model_q[i].age++;
      if (in_fire) model_q.push_back('{data: id, age: 0});
    end
    cyc++;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    logic took, sk_ordy, stalled;
    int   base, t0, nacc;
    reset_i = 1'b1; flush_i = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;

    // Reset, then the first cycle after release must show ready and no valid.
    step(1, 0, 0, 32'h0, 0, took);
    step(1, 0, 0, 32'h0, 0, took);
    step(0, 0, 0, 32'h0, 0, took);

    // Back-to-back 1,2,3 with no backpressure: out on cycles t0+DEPTH.. .
    base = out_log.size(); t0 = cyc; max_occ = 0;
    for (int k = 1; k <= 3; k++) step(0, 0, 1, 32'(k), 1, took);
    repeat (DEPTH + 3) step(0, 0, 0, 32'h0, 1, took);
    check("lat_count", 32'(out_log.size() - base), 32'd3);
    for (int k = 0; k < 3; k++) begin
      if (base + k < out_log.size()) begin
        check("lat_data", out_log[base+k], 32'(k + 1));
        check("lat_cycle", 32'(out_cyc[base+k]), 32'(t0 + DEPTH + k));
      end
    end
    check("lat_peak_occ", 32'(max_occ), 32'(DEPTH));

    // Downstream stalled: fill up, payload must hold the first word.
    base = out_log.size(); nacc = 0;
    repeat (DEPTH + 3) begin
      step(0, 0, 1, 32'(32'h40 + nacc), 0, took);
      if (took) nacc++;
    end
    #1;
    check("stall_data", out_data, 32'h40);
    check("stall_valid", 32'(out_valid), 32'd1);
`ifndef PIPE_SKID_EN
    check("stall_ready", 32'(in_ready), 32'd0);
    check("stall_occ", 32'(occupancy), 32'(DEPTH));
`endif
    repeat (2 * DEPTH + 2) step(0, 0, 0, 32'h0, 1, took);
    check("stall_drain_count", 32'(out_log.size() - base), 32'(nacc));
    for (int k = 0; k < nacc && base + k < out_log.size(); k++)
      check("stall_drain_data", out_log[base+k], 32'(32'h40 + k));

    // Flush with two entries held and a new word offered: all dropped.
    base = out_log.size();
    step(0, 0, 1, 32'hA1, 0, took);
    step(0, 0, 1, 32'hA2, 0, took);
    step(0, 1, 1, 32'hAA, 0, took);
    #1;
    check("flush_valid", 32'(out_valid), 32'd0);
    check("flush_data", out_data, NOP);
    check("flush_occ", 32'(occupancy), 32'd0);
    repeat (2 * DEPTH + 2) step(0, 0, 0, 32'h0, 1, took);
    check("flush_no_emit", 32'(out_log.size() - base), 32'd0);

    // Reset with three entries in flight: nothing stale may come out.
    base = out_log.size();
    for (int k = 0; k < 3; k++) step(0, 0, 1, 32'(32'h50 + k), 0, took);
    step(1, 0, 1, 32'h77, 1, took);
    #1;
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_occ", 32'(occupancy), 32'd0);
    check("rst_data", out_data, NOP);
    step(0, 0, 0, 32'h0, 0, took);
    #1;
    check("rst_ready", 32'(in_ready), 32'd1);
    repeat (2 * DEPTH + 2) step(0, 0, 0, 32'h0, 1, took);
    check("rst_no_emit", 32'(out_log.size() - base), 32'd0);

`ifdef PIPE_SKID_EN
    // Stream 0x10..0x17 with one stall cycle while 0x12 is at the output.
    base = out_log.size(); nacc = 0; max_occ = 0; stalled = 1'b0;
    for (int n = 0; n < 60 && out_log.size() - base < 8; n++) begin
      sk_ordy = !(!stalled && out_valid && out_data == 32'h12);
      if (!sk_ordy) stalled = 1'b1;
      step(0, 0, nacc < 8, 32'(32'h10 + nacc), sk_ordy, took);
      if (took) nacc++;
    end
    check("skid_stalled", 32'(stalled), 32'd1);
    check("skid_count", 32'(out_log.size() - base), 32'd8);
    for (int k = 0; k < 8 && base + k < out_log.size(); k++)
      check("skid_data", out_log[base+k], 32'(32'h10 + k));
    check("skid_max_occ", 32'(max_occ <= 2 * DEPTH), 32'd1);
`endif

    // Random valid/ready at 50% with occasional flush.
    max_occ = 0;
    repeat (10000)
      step(0, ($urandom_range(0, 99) == 0), 1'($urandom_range(0, 1)), $urandom,
           1'($urandom_range(0, 1)), took);
    repeat (3 * DEPTH) step(0, 0, 0, 32'h0, 1, took);
    check("rand_drained", 32'(occupancy), 32'd0);
    check("rand_max_occ", 32'(max_occ <= CAP), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
